// File: rtl/reg_bank_reader_pkg.sv
// Shared definitions for the register-bank readback sequencer: default widths and FSM encodings.
package reg_bank_reader_pkg;

    localparam int unsigned RBR_DATA_WIDTH = 32;
    localparam int unsigned RBR_ADDR_WIDTH = 5;

    typedef enum logic [2:0] {
        RBR_IDLE    = 3'd0,
        RBR_ISSUE   = 3'd1,
        RBR_WAIT    = 3'd2,
        RBR_PRESENT = 3'd3,
        RBR_FIN     = 3'd4
    } rbr_state_e;

endpackage

// File: rtl/reg_bank_reader_ctr.sv
// Address and remaining-word counters for reg_bank_reader; address wraps modulo 2**ADDR_WIDTH.
module reg_bank_reader_ctr
    import reg_bank_reader_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = RBR_ADDR_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_load,
    input  logic                  i_step,
    input  logic [ADDR_WIDTH-1:0] i_base_addr,
    input  logic [ADDR_WIDTH:0]   i_num,
    output logic [ADDR_WIDTH-1:0] o_cur_addr,
    output logic                  o_last_c
);

    localparam int unsigned CNT_WIDTH = ADDR_WIDTH + 1;

    logic [ADDR_WIDTH-1:0] r_addr;
    logic [CNT_WIDTH-1:0]  r_remain;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_addr   <= '0;
            r_remain <= '0;
        end else if (i_load) begin
            r_addr   <= i_base_addr;
            r_remain <= i_num;
        end else if (i_step) begin
            r_addr   <= r_addr + ADDR_WIDTH'(1);
            r_remain <= r_remain - CNT_WIDTH'(1);
        end
    end

    assign o_cur_addr = r_addr;
    assign o_last_c   = (r_remain == CNT_WIDTH'(1));

endmodule

// File: rtl/reg_bank_reader.sv
// Register-bank readback sequencer: reads NUM words from BASE_ADDR and presents {addr,data} on valid/ready.
// Optional READBACK_PARITY_EN adds o_out_parity (even parity of o_out_data).
module reg_bank_reader
    import reg_bank_reader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = RBR_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = RBR_ADDR_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_base_addr,
    input  logic [ADDR_WIDTH:0]   i_num,
    output logic                  o_rf_read,
    output logic [ADDR_WIDTH-1:0] o_rf_addr,
    input  logic [DATA_WIDTH-1:0] i_rf_data,
    output logic                  o_out_valid,
    input  logic                  i_out_ready,
    output logic [DATA_WIDTH-1:0] o_out_data,
    output logic [ADDR_WIDTH-1:0] o_out_addr,
    output logic                  o_busy,
    output logic                  o_done
`ifdef READBACK_PARITY_EN
    ,
    output logic                  o_out_parity
`endif
);

    rbr_state_e            r_state;
    rbr_state_e            w_state_nxt;
    logic                  w_load;
    logic                  w_step;
    logic                  w_last;
    logic [ADDR_WIDTH-1:0] w_cur_addr;

    logic                  r_rf_read;
    logic                  r_out_valid;
    logic                  r_busy;
    logic                  r_done;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic [ADDR_WIDTH-1:0] r_out_addr;

    reg_bank_reader_ctr #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ctr (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_load      (w_load),
        .i_step      (w_step),
        .i_base_addr (i_base_addr),
        .i_num       (i_num),
        .o_cur_addr  (w_cur_addr),
        .o_last_c    (w_last)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= RBR_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        unique case (r_state)
            RBR_IDLE: begin
                if (i_start) begin
                    w_load      = 1'b1;
                    w_state_nxt = (i_num == '0) ? RBR_FIN : RBR_ISSUE;
                end
            end
            RBR_ISSUE:   w_state_nxt = RBR_WAIT;
            RBR_WAIT:    w_state_nxt = RBR_PRESENT;
            RBR_PRESENT: begin
                if (i_out_ready) begin
                    w_step      = 1'b1;
                    w_state_nxt = w_last ? RBR_FIN : RBR_ISSUE;
                end
            end
            RBR_FIN:     w_state_nxt = RBR_IDLE;
            default:     w_state_nxt = RBR_IDLE;
        endcase
    end

    // Status strobes are registered decodes of the next state so they line up with r_state.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rf_read   <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_rf_read   <= (w_state_nxt == RBR_ISSUE);
            r_out_valid <= (w_state_nxt == RBR_PRESENT);
            r_busy      <= (w_state_nxt != RBR_IDLE);
            r_done      <= (w_state_nxt == RBR_FIN);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_out_data <= '0;
            r_out_addr <= '0;
        end else if (r_state == RBR_WAIT) begin
            r_out_data <= i_rf_data;
            r_out_addr <= w_cur_addr;
        end
    end

`ifdef READBACK_PARITY_EN
    logic r_out_parity;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_out_parity <= 1'b0;
        end else if (r_state == RBR_WAIT) begin
            r_out_parity <= ^i_rf_data;
        end
    end

    assign o_out_parity = r_out_parity;
`endif

    assign o_rf_read   = r_rf_read;
    assign o_rf_addr   = w_cur_addr;
    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;
    assign o_out_addr  = r_out_addr;
    assign o_busy      = r_busy;
    assign o_done      = r_done;

endmodule

// File: tb/tb_reg_bank_reader.sv
// Self-checking bench for reg_bank_reader: vector table plus hand sequences, scoreboard on the output handshake.
module tb_reg_bank_reader;

    typedef struct {
        logic [4:0] base;
        logic [5:0] num;
        int         exp_done_cyc;
        logic [4:0] exp_last_addr;
    } vec_t;

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } word_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [4:0]  base;
    logic [5:0]  num;
    logic        rf_read;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_addr;
    logic        busy;
    logic        done;
`ifdef READBACK_PARITY_EN
    logic        out_parity;
`endif

    logic [31:0] bank [32];
    word_t       sb [$];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          rd_cnt;
    int          done_cnt;
    int          words;
    logic [4:0]  last_addr;

    reg_bank_reader dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start),
        .i_base_addr (base),
        .i_num       (num),
        .o_rf_read   (rf_read),
        .o_rf_addr   (rf_addr),
        .i_rf_data   (rf_data),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_out_data  (out_data),
        .o_out_addr  (out_addr),
        .o_busy      (busy),
        .o_done      (done)
`ifdef READBACK_PARITY_EN
        ,
        .o_out_parity (out_parity)
`endif
    );

    always #5 clk = ~clk;

    // Register file model: data valid the cycle after the read strobe, garbage otherwise.
    always @(posedge clk) begin
        if (rf_read) rf_data <= bank[rf_addr];
        else         rf_data <= 32'hDEAD_BEEF;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (rf_read) rd_cnt++;
            if (done)    done_cnt++;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_word", 64'(out_addr), 64'hFFFF);
                end else begin
                    word_t e;
                    e = sb.pop_front();
                    chk("word_addr", 64'(out_addr), 64'(e.a));
                    chk("word_data", 64'(out_data), 64'(e.d));
`ifdef READBACK_PARITY_EN
                    chk("word_parity", 64'(out_parity), 64'(^e.d));
`endif
                    words++;
                    last_addr = out_addr;
                end
            end
        end
    end

    task automatic push_words(input logic [4:0] b, input logic [5:0] n);
        for (int i = 0; i < int'(n); i++) begin
            word_t w;
            w.a = b + 5'(i);
            w.d = bank[w.a];
            sb.push_back(w);
        end
    endtask

    task automatic do_xfer(input logic [4:0] b, input logic [5:0] n, input int exp_done,
                           input logic [4:0] exp_last, input bit fin_restart);
        int cyc;
        int first_v;
        bit got_done;
        rd_cnt = 0; done_cnt = 0; words = 0;
        push_words(b, n);
        @(posedge clk); #1;
        start = 1'b1; base = b; num = n;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0; first_v = 0; got_done = 1'b0;
        while (!got_done && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (out_valid && first_v == 0) first_v = cyc;
            if (done) got_done = 1'b1;
        end
        chk("done_seen", 64'(got_done), 64'd1);
        chk("done_cycle", 64'(cyc), 64'(exp_done));
        if (fin_restart) begin
            start = 1'b1; base = 5'd20; num = 6'd1;
            @(posedge clk); #1;
            start = 1'b0;
            @(negedge clk);
            chk("fin_start_ignored", 64'({busy, rf_read}), 64'd0);
        end
        repeat (2) @(negedge clk);
        chk("rf_read_count", 64'(rd_cnt), 64'(n));
        chk("done_count", 64'(done_cnt), 64'd1);
        chk("word_count", 64'(words), 64'(n));
        chk("sb_empty", 64'(sb.size()), 64'd0);
        chk("idle_after", 64'(busy), 64'd0);
        if (n != 0) begin
            chk("first_valid_cycle", 64'(first_v), 64'd3);
            chk("last_addr", 64'(last_addr), 64'(exp_last));
        end
        sb.delete();
    endtask

    initial begin
        vec_t vecs [6];
        logic [45:0] all_out;
        bit          ok;

        vecs[0] = '{5'd3,  6'd4,  13, 5'd6};
        vecs[1] = '{5'd30, 6'd4,  13, 5'd1};
        vecs[2] = '{5'd0,  6'd0,  1,  5'd0};
        vecs[3] = '{5'd7,  6'd1,  4,  5'd7};
        vecs[4] = '{5'd0,  6'd32, 97, 5'd31};
        vecs[5] = '{5'd31, 6'd2,  7,  5'd0};

        for (int i = 0; i < 32; i++) bank[i] = 32'(i) * 32'h11;
`ifdef READBACK_PARITY_EN
        bank[8] = 32'h0000_0007;
        bank[9] = 32'h0000_0003;
`endif
        rst = 1'b1; start = 1'b0; base = '0; num = '0; out_ready = 1'b0;
        rd_cnt = 0; done_cnt = 0; words = 0; last_addr = '0;

        repeat (3) @(posedge clk); #1;
        all_out = {rf_read, rf_addr, out_valid, out_data, out_addr, busy, done};
        chk("reset_outputs", 64'(all_out), 64'd0);
        rst = 1'b0;

        // Reset while a word at address 5 is pending in PRESENT.
        @(posedge clk); #1;
        start = 1'b1; base = 5'd5; num = 6'd3;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 20 && !out_valid; k++) @(negedge clk);
        chk("t1_pending_valid", 64'(out_valid), 64'd1);
        chk("t1_pending_addr", 64'(out_addr), 64'd5);
        chk("t1_pending_data", 64'(out_data), 64'(bank[5]));
        #2 rst = 1'b1;
        #1;
        all_out = {rf_read, rf_addr, out_valid, out_data, out_addr, busy, done};
        chk("t1_reset_outputs", 64'(all_out), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0; out_ready = 1'b1;
        ok = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (busy || out_valid || rf_read || done) ok = 1'b0;
        end
        chk("t1_idle_after_release", 64'(ok), 64'd1);

        for (int v = 0; v < 6; v++)
            do_xfer(vecs[v].base, vecs[v].num, vecs[v].exp_done_cyc, vecs[v].exp_last_addr, 1'b0);

        // START during FIN must not launch another readback.
        do_xfer(5'd2, 6'd1, 4, 5'd2, 1'b1);

        // Stall in PRESENT for 10 cycles with stray START pulses.
        rd_cnt = 0; done_cnt = 0; words = 0;
        @(posedge clk); #1;
        out_ready = 1'b0;
        push_words(5'd10, 6'd2);
        start = 1'b1; base = 5'd10; num = 6'd2;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 20 && !out_valid; k++) @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("stall_hold", 64'({out_valid, out_addr, out_data}), 64'({1'b1, 5'd10, bank[10]}));
            start = k[0]; base = 5'(k); num = 6'd1;
        end
        start = 1'b0;
        @(posedge clk); #1;
        out_ready = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 40 && !ok; k++) begin
            @(negedge clk);
            if (done) ok = 1'b1;
        end
        chk("stall_done", 64'(ok), 64'd1);
        repeat (2) @(negedge clk);
        chk("stall_words", 64'(words), 64'd2);
        chk("stall_rf_reads", 64'(rd_cnt), 64'd2);
        chk("stall_sb_empty", 64'(sb.size()), 64'd0);

`ifdef READBACK_PARITY_EN
        do_xfer(5'd8, 6'd2, 7, 5'd9, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
